// File: rtl/slc3_isdu.sv
// slc3_isdu: SLC-3 fetch/decode/execute control FSM; memory strobes are held for MEM_WAIT cycles.
// Define SLC3_PAUSE_EN to add the PAUSE opcode (1101) with its P1/P2 handshake on Continue.
module slc3_isdu #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MARMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MIO_EN,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    S_HALTED,
    S_F1,
    S_F2,
    S_F3,
    S_DEC,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR_T,
    S_JMP,
    S_JSR1,
    S_JSR2,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3
`ifdef SLC3_PAUSE_EN
    , S_P1,
    S_P2
`endif
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       mem_last;

  assign mem_last = (wait_q == WAIT_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_HALTED;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter only advances inside a memory state; every exit lands it back at 0.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    MARMUX     = 1'b0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    MIO_EN     = 1'b0;
    PCMUX      = 2'd0;
    ADDR2MUX   = 2'd0;
    ALUK       = 2'd0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    case (state_q)
      S_HALTED: if (Run) state_d = S_F1;
      S_F1: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        state_d = S_F2;
      end
      S_F2, S_LDR2: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = mem_last;
        if (mem_last) state_d = (state_q == S_F2) ? S_F3 : S_LDR3;
        else          wait_d  = wait_q + 3'd1;
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = BEN ? S_BR_T : S_F1;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR1;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
`ifdef SLC3_PAUSE_EN
          4'b1101: state_d = S_P1;
`endif
          default: state_d = S_F1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX  = 1'b1;
        SR2MUX  = ~IR_5;
        ALUK    = (state_q == S_ADD) ? 2'd0 : (state_q == S_AND) ? 2'd1 : 2'd2;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_F1;
      end
      S_BR_T: begin
        ADDR2MUX = 2'd2;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
        state_d  = S_F1;
      end
      S_JMP: begin
        ADDR1MUX = 1'b1;
        SR1MUX   = 1'b1;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
        state_d  = S_F1;
      end
      S_JSR1: begin
        GatePC  = 1'b1;
        DRMUX   = 1'b1;
        LD_REG  = 1'b1;
        state_d = S_JSR2;
      end
      S_JSR2: begin
        ADDR1MUX = ~IR_11;
        SR1MUX   = ~IR_11;
        ADDR2MUX = IR_11 ? 2'd3 : 2'd0;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
        state_d  = S_F1;
      end
      S_LDR1, S_STR1: begin
        ADDR1MUX   = 1'b1;
        SR1MUX     = 1'b1;
        ADDR2MUX   = 2'd1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_d    = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_F1;
      end
      S_STR2: begin
        ALUK    = 2'd3;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        state_d = S_STR3;
      end
      S_STR3: begin
        Mem_WE = 1'b1;
        if (mem_last) state_d = S_F1;
        else          wait_d  = wait_q + 3'd1;
      end
`ifdef SLC3_PAUSE_EN
      S_P1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_P2;
      end
      S_P2: if (!Continue) state_d = S_F1;
`endif
      default: state_d = S_HALTED;
    endcase
  end

endmodule
